// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared types and constants for the burst shift register
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shifter_cell.sv
// rtl/shifter_cell.sv - one bit of the shift register: next-value select
module shifter_cell
  import shift_ctrl_pkg::*;
(
  input  logic own_bit,
  input  logic left_bit,
  input  logic right_bit,
  input  logic load_bit,
  input  logic shift_en,
  input  logic dir,
  input  logic load_n,
  output logic next_bit
);

  // Parallel load wins, then shift (left shift pulls from the lower neighbour), else hold.
  always_comb begin
    next_bit = own_bit;
    if (!load_n) begin
      next_bit = load_bit;
    end else if (shift_en) begin
      next_bit = (dir == DIR_LEFT) ? right_bit : left_bit;
    end
  end

endmodule

// File: rtl/shift_register_ctrl.sv
// rtl/shift_register_ctrl.sv - WIDTH-bit shift register with counted burst controller
module shift_register_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOAD_N,
  input  logic [WIDTH-1:0] LOAD,
  input  logic             START,
  input  logic [CW-1:0]    COUNT,
  input  logic             DIR,
  input  logic             ROTATE,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] Q,
  output logic             SERIAL_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    remaining_next;
  logic             dir_l;
  logic             dir_l_next;
  logic             rot_l;
  logic             rot_l_next;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] left_nb;
  logic [WIDTH-1:0] right_nb;
  logic [CW-1:0]    n_clamped;
  logic             shift_en;
  logic             fill;
  logic             eff_dir;

  // Bursts longer than the register are pointless, so COUNT saturates at WIDTH.
  assign n_clamped = (COUNT > WIDTH_CW) ? WIDTH_CW : COUNT;

  assign shift_en = (state == SHIFT);

  // The fill bit only ever enters at one end, chosen by the latched direction.
  assign fill = rot_l ? ((dir_l == DIR_LEFT) ? q_reg[WIDTH-1] : q_reg[0]) : SERIAL_IN;

  // Neighbour vectors: the end cells see the fill bit in place of a missing neighbour.
  assign left_nb  = {fill, q_reg[WIDTH-1:1]};
  assign right_nb = {q_reg[WIDTH-2:0], fill};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      shifter_cell u_cell (
        .own_bit   (q_reg[gi]),
        .left_bit  (left_nb[gi]),
        .right_bit (right_nb[gi]),
        .load_bit  (LOAD[gi]),
        .shift_en  (shift_en),
        .dir       (dir_l),
        .load_n    (LOAD_N),
        .next_bit  (q_next[gi])
      );
    end
  endgenerate

  // Register bank; the cells already resolve load/shift/hold priority.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q_reg <= RESET_VALUE;
    end else begin
      q_reg <= q_next;
    end
  end

  // Controller state, remaining-shift counter and latched mode bits.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      remaining <= '0;
      dir_l     <= 1'b0;
      rot_l     <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      dir_l     <= dir_l_next;
      rot_l     <= rot_l_next;
    end
  end

  // Next-state logic: a load aborts anything; START is only heard in IDLE.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    dir_l_next     = dir_l;
    rot_l_next     = rot_l;
    if (!LOAD_N) begin
      state_next     = IDLE;
      remaining_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            dir_l_next = DIR;
            rot_l_next = ROTATE;
            if (n_clamped == '0) begin
              state_next = FINISH;
            end else begin
              remaining_next = n_clamped;
              state_next     = SHIFT;
            end
          end
        end
        SHIFT: begin
          remaining_next = remaining - ONE_CW;
          if (remaining == ONE_CW) begin
            state_next = FINISH;
          end
        end
        FINISH: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // During a burst the exiting bit follows the latched direction, not the live input.
  assign eff_dir    = (state == SHIFT) ? dir_l : DIR;
  assign SERIAL_OUT = (eff_dir == DIR_LEFT) ? q_reg[WIDTH-1] : q_reg[0];

  assign Q    = q_reg;
  assign BUSY = (state == SHIFT);
  assign DONE = (state == FINISH);

endmodule

// File: tb/tb_shift_register_ctrl.sv
// tb/tb_shift_register_ctrl.sv - scoreboard bench for shift_register_ctrl
module tb_shift_register_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       LOAD_N = 1'b1;
  logic [7:0] LOAD = 8'h00;
  logic       START = 1'b0;
  logic [3:0] COUNT = 4'd0;
  logic       DIR = 1'b0;
  logic       ROTATE = 1'b0;
  logic       SERIAL_IN = 1'b0;
  logic [7:0] Q;
  logic       SERIAL_OUT;
  logic       BUSY;
  logic       DONE;

  bit         clk_en = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] q_m = 8'h00;
  logic [8:0] sb[$];
  logic [8:0] mon_e;

  shift_register_ctrl #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .LOAD_N     (LOAD_N),
    .LOAD       (LOAD),
    .START      (START),
    .COUNT      (COUNT),
    .DIR        (DIR),
    .ROTATE     (ROTATE),
    .SERIAL_IN  (SERIAL_IN),
    .Q          (Q),
    .SERIAL_OUT (SERIAL_OUT),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 if (clk_en) CLK = ~CLK;

  function automatic logic [7:0] mshift(logic [7:0] q, logic d, logic r, logic si);
    logic f;
    if (d) begin
      f = r ? q[7] : si;
      return {q[6:0], f};
    end
    f = r ? q[0] : si;
    return {f, q[7:1]};
  endfunction

  // Scoreboard consumer: every BUSY cycle must match the next expected {Q, SERIAL_OUT}.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      if (DONE === 1'b1) done_cnt++;
      if (BUSY === 1'b1) begin
        busy_cnt++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: BUSY with Q=%h but no shift expected", Q);
        end else begin
          mon_e = sb.pop_front();
          if ({Q, SERIAL_OUT} !== mon_e) begin
            bad++;
            $display("FAIL shift_step: got Q=%h so=%b expected Q=%h so=%b",
                     Q, SERIAL_OUT, mon_e[8:1], mon_e[0]);
          end
        end
      end
    end
  end

  task automatic do_load(input logic [7:0] v);
    LOAD = v;
    LOAD_N = 1'b0;
    @(negedge CLK);
    LOAD_N = 1'b1;
    q_m = v;
  endtask

  task automatic do_start(input int cnt, input logic d, input logic r, input logic si);
    int n;
    n = (cnt > 8) ? 8 : cnt;
    COUNT = 4'(cnt);
    DIR = d;
    ROTATE = r;
    SERIAL_IN = si;
    START = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      sb.push_back({q_m, d ? q_m[7] : q_m[0]});
      q_m = mshift(q_m, d, r, si);
    end
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      @(negedge CLK);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 RESET_N = 1'b0;
    #1;
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h expected 00", Q); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", DONE); end
    clk_en = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL idle_q: got %h expected 00", Q); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL idle_flags: got busy=%b done=%b expected 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_load_left();
    do_load(8'hA5);
    total++; if (Q !== 8'hA5) begin bad++; $display("FAIL load_q: got %h expected a5", Q); end
    do_start(4, 1'b1, 1'b0, 1'b1);
    wait_done(20);
    total++; if (Q !== 8'h5F) begin bad++; $display("FAIL left_final: got %h expected 5f", Q); end
    total++; if (busy_cnt != 4) begin bad++; $display("FAIL left_busy: got %0d expected 4", busy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL left_done: got %0d expected 1", done_cnt); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL left_sb: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_rotate_right();
    do_load(8'h81);
    do_start(1, 1'b0, 1'b1, 1'b0);
    wait_done(20);
    total++; if (Q !== 8'hC0) begin bad++; $display("FAIL rot1_q: got %h expected c0", Q); end
    total++; if (busy_cnt != 1) begin bad++; $display("FAIL rot1_busy: got %0d expected 1", busy_cnt); end
    do_load(8'h81);
    do_start(8, 1'b0, 1'b1, 1'b1);
    wait_done(30);
    total++; if (Q !== 8'h81 || Q !== q_m) begin bad++; $display("FAIL rot8_q: got %h expected 81", Q); end
    total++; if (busy_cnt != 8) begin bad++; $display("FAIL rot8_busy: got %0d expected 8", busy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rot8_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_abort();
    int b0;
    int d0;
    do_load(8'hE7);
    do_start(6, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    LOAD = 8'h3C;
    LOAD_N = 1'b0;
    START = 1'b1;
    COUNT = 4'd2;
    @(negedge CLK);
    LOAD_N = 1'b1;
    START = 1'b0;
    q_m = 8'h3C;
    total++; if (Q !== 8'h3C) begin bad++; $display("FAIL abort_q: got %h expected 3c", Q); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
    total++; if (sb.size() != 2) begin bad++; $display("FAIL abort_sb: got %0d left expected 2", sb.size()); end
    sb.delete();
    b0 = busy_cnt;
    d0 = done_cnt;
    repeat (4) @(negedge CLK);
    total++; if (done_cnt != d0 || done_cnt != 0) begin
      bad++; $display("FAIL abort_nodone: got %0d done pulses expected 0", done_cnt);
    end
    total++; if (busy_cnt != b0 || Q !== 8'h3C) begin
      bad++; $display("FAIL abort_start_ignored: got busy_cycles=%0d Q=%h expected %0d 3c", busy_cnt, Q, b0);
    end
  endtask

  task automatic test_count_zero();
    do_load(8'h5A);
    do_start(0, 1'b1, 1'b0, 1'b1);
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL zero_done_time: got %b expected 1", DONE); end
    wait_done(10);
    total++; if (busy_cnt != 0) begin bad++; $display("FAIL zero_busy: got %0d expected 0", busy_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
    total++; if (Q !== 8'h5A) begin bad++; $display("FAIL zero_q: got %h expected 5a", Q); end
  endtask

  task automatic test_clamp();
    do_load(8'h96);
    do_start(12, 1'b1, 1'b0, 1'b1);
    wait_done(30);
    total++; if (busy_cnt != 8) begin bad++; $display("FAIL clamp_busy: got %0d expected 8", busy_cnt); end
    total++; if (Q !== 8'hFF) begin bad++; $display("FAIL clamp_q: got %h expected ff", Q); end
  endtask

  task automatic test_back_to_back();
    do_load(8'h01);
    do_start(3, 1'b1, 1'b0, 1'b0);
    START = 1'b1;
    COUNT = 4'd5;
    DIR = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    wait_done(20);
    total++; if (Q !== 8'h08) begin bad++; $display("FAIL busy_start_q: got %h expected 08", Q); end
    total++; if (busy_cnt != 3) begin bad++; $display("FAIL busy_start_cnt: got %0d expected 3", busy_cnt); end
    total++; if (SERIAL_OUT !== 1'b0) begin bad++; $display("FAIL idle_so_dir: got %b expected 0", SERIAL_OUT); end
    DIR = 1'b1;
    do_load(8'h80);
    total++; if (SERIAL_OUT !== 1'b1) begin bad++; $display("FAIL idle_so_left: got %b expected 1", SERIAL_OUT); end
  endtask

  task automatic test_async_reset_mid();
    do_load(8'hC3);
    do_start(5, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    total++; if (Q !== 8'h00) begin bad++; $display("FAIL areset_q: got %h expected 00", Q); end
    total++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL areset_flags: got busy=%b done=%b expected 0 0", BUSY, DONE);
    end
    total++; if (sb.size() != 2) begin bad++; $display("FAIL areset_sb: got %0d left expected 2", sb.size()); end
    sb.delete();
    q_m = 8'h00;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    do_start(3, 1'b1, 1'b0, 1'b1);
    wait_done(20);
    total++; if (Q !== 8'h07) begin bad++; $display("FAIL post_reset_q: got %h expected 07", Q); end
    total++; if (busy_cnt != 3 || done_cnt != 1) begin
      bad++; $display("FAIL post_reset_burst: got busy=%0d done=%0d expected 3 1", busy_cnt, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_left();
    test_rotate_right();
    test_abort();
    test_count_zero();
    test_clamp();
    test_back_to_back();
    test_async_reset_mid();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL final_sb: got %0d left expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
